// File: rtl/axi_cdc_pwr_ctrl_pkg.sv
// Shared types and helpers for the AXI CDC master-side power sequencer.
package axi_cdc_pwr_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } pwr_state_e;

  // Bits needed to hold the values 0..max inclusive.
  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/axi_cdc_pwr_ctrl_if.sv
// Master-side AXI handshake wires (valid/ready/last only) seen by the power sequencer.
interface axi_cdc_pwr_ctrl_if;

  logic aw_valid;
  logic aw_ready;
  logic ar_valid;
  logic ar_ready;
  logic b_valid;
  logic b_ready;
  logic r_valid;
  logic r_ready;
  logic r_last;

  modport master (
    output aw_valid, ar_valid, b_ready, r_ready,
    input  aw_ready, ar_ready, b_valid, r_valid, r_last
  );

  modport slave (
    input  aw_valid, ar_valid, b_ready, r_ready,
    output aw_ready, ar_ready, b_valid, r_valid, r_last
  );

  // Passive tap: the power sequencer only observes the handshakes.
  modport monitor (
    input aw_valid, aw_ready, ar_valid, ar_ready,
    input b_valid, b_ready, r_valid, r_ready, r_last
  );

endinterface

// File: rtl/axi_cdc_pwr_ctrl_ctr.sv
// Saturating up/down outstanding-burst counter with a sticky over/underflow flag.
module axi_cdc_pwr_ctr
  import axi_cdc_pwr_pkg::*;
#(
  parameter  int MAX = 16,
  localparam int W   = cnt_width(MAX)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt_next,
  output logic         err
);

  logic [W-1:0] cnt;
  logic         bad_op;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_next = cnt;
    bad_op   = 1'b0;
    if (inc && !dec) begin
      if (cnt == W'(MAX)) bad_op   = 1'b1;
      else                cnt_next = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt == '0) bad_op   = 1'b1;
      else           cnt_next = cnt - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (bad_op) err <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_cdc_pwr_ctrl.sv
// Power/isolation sequencer for the master side of the AXI dual-clock CDC.
// Optional idle auto-sleep is built when AXI_CDC_PWR_CTRL_IDLE_TIMER_EN is defined.
module axi_cdc_pwr_ctrl
  import axi_cdc_pwr_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int WAKE_CYCLES     = 4,
  parameter int IDLE_CYCLES     = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sleep_req_i,
  input  logic                       incoming_req_i,
  axi_cdc_pwr_ctrl_if.monitor        axi,
  output logic                       sleep_ack_o,
  output logic                       isolate_o,
  output logic                       clock_down_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam int WW = cnt_width(WAKE_CYCLES);

  if (WAKE_CYCLES < 1) begin : g_bad_wake
    $error("WAKE_CYCLES must be at least 1");
  end
  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("IDLE_CYCLES must be at least 1");
  end

  pwr_state_e    state, state_nxt;
  logic [CW-1:0] wr_next, rd_next;
  logic          wr_err, rd_err;
  logic [WW-1:0] wake_cnt;
  logic          lockout;
  logic          go_sleep, sleep_hold;
  logic          iso_nxt, down_nxt, ack_nxt;

  logic aw_hs, ar_hs, b_hs, rlast_hs;
  assign aw_hs    = axi.aw_valid & axi.aw_ready;
  assign ar_hs    = axi.ar_valid & axi.ar_ready;
  assign b_hs     = axi.b_valid  & axi.b_ready;
  assign rlast_hs = axi.r_valid  & axi.r_ready & axi.r_last;

  axi_cdc_pwr_ctr #(.MAX(MAX_OUTSTANDING)) u_wr_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc      (aw_hs),
    .dec      (b_hs),
    .cnt_next (wr_next),
    .err      (wr_err)
  );

  axi_cdc_pwr_ctr #(.MAX(MAX_OUTSTANDING)) u_rd_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc      (ar_hs),
    .dec      (rlast_hs),
    .cnt_next (rd_next),
    .err      (rd_err)
  );

  assign err_o = wr_err | rd_err;

`ifdef AXI_CDC_PWR_CTRL_IDLE_TIMER_EN
  localparam int IW = cnt_width(IDLE_CYCLES);

  logic [IW-1:0] idle_cnt;
  logic          idle_ok, auto_fire, auto_sleep;

  assign idle_ok   = (state == RUN) && !busy_o && !aw_hs && !ar_hs;
  assign auto_fire = idle_ok && (idle_cnt == IW'(IDLE_CYCLES - 1));

  // The auto-sleep source holds the sequencer asleep until an incoming request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt   <= '0;
      auto_sleep <= 1'b0;
    end else begin
      idle_cnt <= (idle_ok && !auto_fire) ? idle_cnt + 1'b1 : '0;
      if (auto_fire)                              auto_sleep <= 1'b1;
      else if (state == SLEEP && state_nxt == WAKE) auto_sleep <= 1'b0;
    end
  end

  assign go_sleep   = (sleep_req_i & ~lockout) | auto_fire | auto_sleep;
  assign sleep_hold = sleep_req_i | auto_sleep;
`else
  assign go_sleep   = sleep_req_i & ~lockout;
  assign sleep_hold = sleep_req_i;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:   if (go_sleep) state_nxt = DRAIN;
      DRAIN: begin
        // Counters are checked post-update so a final response drains in its own cycle.
        if (!sleep_hold)                       state_nxt = RUN;
        else if (wr_next == '0 && rd_next == '0) state_nxt = SLEEP;
      end
      SLEEP: if (incoming_req_i || !sleep_hold) state_nxt = WAKE;
      WAKE:  if (wake_cnt == '0) state_nxt = RUN;
    endcase
  end

  always_comb begin
    iso_nxt  = (state_nxt != RUN);
    down_nxt = (state_nxt == SLEEP);
    ack_nxt  = (state_nxt == SLEEP);
  end

  // NOTE: reset is synchronous, so it only takes effect on a clock edge and sits inside the clocked branch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= RUN;
      isolate_o    <= 1'b0;
      clock_down_o <= 1'b0;
      sleep_ack_o  <= 1'b0;
      busy_o       <= 1'b0;
      wake_cnt     <= '0;
      lockout      <= 1'b0;
    end else begin
      state        <= state_nxt;
      isolate_o    <= iso_nxt;
      clock_down_o <= down_nxt;
      sleep_ack_o  <= ack_nxt;
      busy_o       <= (wr_next != '0) || (rd_next != '0);

      if (state_nxt == WAKE && state != WAKE) wake_cnt <= WW'(WAKE_CYCLES - 1);
      else if (state == WAKE && wake_cnt != '0) wake_cnt <= wake_cnt - 1'b1;

      // Lockout blocks re-sleep after an incoming-request wake until the request toggles.
      if (!sleep_req_i)                        lockout <= 1'b0;
      else if (state == SLEEP && incoming_req_i) lockout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_cdc_pwr_ctrl.sv
// Directed self-checking bench for axi_cdc_pwr_ctrl (default build, WAKE_CYCLES=4, MAX_OUTSTANDING=16).
module tb_axi_cdc_pwr_ctrl;

  logic clk_i = 1'b0;
  logic rst_i;
  logic sleep_req_i;
  logic incoming_req_i;
  logic sleep_ack_o, isolate_o, clock_down_o, busy_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  axi_cdc_pwr_ctrl_if axi_bus ();

  axi_cdc_pwr_ctrl #(
    .MAX_OUTSTANDING (16),
    .WAKE_CYCLES     (4),
    .IDLE_CYCLES     (256)
  ) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sleep_req_i    (sleep_req_i),
    .incoming_req_i (incoming_req_i),
    .axi            (axi_bus),
    .sleep_ack_o    (sleep_ack_o),
    .isolate_o      (isolate_o),
    .clock_down_o   (clock_down_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic iso, input logic down,
                           input logic ack, input logic busy, input logic err);
    check({tag, "_isolate"},    isolate_o,    iso);
    check({tag, "_clock_down"}, clock_down_o, down);
    check({tag, "_sleep_ack"},  sleep_ack_o,  ack);
    check({tag, "_busy"},       busy_o,       busy);
    check({tag, "_err"},        err_o,        err);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic clear_bus();
    axi_bus.aw_valid = 1'b0; axi_bus.aw_ready = 1'b0;
    axi_bus.ar_valid = 1'b0; axi_bus.ar_ready = 1'b0;
    axi_bus.b_valid  = 1'b0; axi_bus.b_ready  = 1'b0;
    axi_bus.r_valid  = 1'b0; axi_bus.r_ready  = 1'b0;
    axi_bus.r_last   = 1'b0;
  endtask

  task automatic set_aw(input logic v); axi_bus.aw_valid = v; axi_bus.aw_ready = v; endtask
  task automatic set_ar(input logic v); axi_bus.ar_valid = v; axi_bus.ar_ready = v; endtask
  task automatic set_b (input logic v); axi_bus.b_valid  = v; axi_bus.b_ready  = v; endtask
  task automatic set_r (input logic v, input logic last);
    axi_bus.r_valid = v; axi_bus.r_ready = v; axi_bus.r_last = last;
  endtask

  initial begin
    rst_i = 1'b1; sleep_req_i = 1'b0; incoming_req_i = 1'b0;
    clear_bus();
    step(2);
    check_all("reset", 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    step(1);
    check_all("run_idle", 0, 0, 0, 0, 0);

    // Sleep entry with no traffic: isolate at +1, ack/clock-down at +2.
    sleep_req_i = 1'b1;
    step(1);
    check("t1_iso_c1", isolate_o, 1'b1);
    check("t1_ack_c1", sleep_ack_o, 1'b0);
    step(1);
    check("t1_ack_c2", sleep_ack_o, 1'b1);
    check("t1_down_c2", clock_down_o, 1'b1);
    // Wake by releasing the request: isolate drops WAKE_CYCLES+1 cycles later.
    sleep_req_i = 1'b0;
    step(1);
    check("t1_wake_down", clock_down_o, 1'b0);
    check("t1_wake_iso", isolate_o, 1'b1);
    check("t1_wake_ack", sleep_ack_o, 1'b0);
    step(3);
    check("t1_wake_iso_c4", isolate_o, 1'b1);
    step(1);
    check("t1_wake_iso_c5", isolate_o, 1'b0);

    // Three writes outstanding; drain waits for the third B.
    set_aw(1'b1);
    step(3);
    set_aw(1'b0);
    check("t2_busy", busy_o, 1'b1);
    sleep_req_i = 1'b1;
    step(1);
    check("t2_drain_iso", isolate_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_b(1'b1);
      step(1);
      set_b(1'b0);
      if (i < 2) begin
        check($sformatf("t2_b%0d_ack", i), sleep_ack_o, 1'b0);
        check($sformatf("t2_b%0d_busy", i), busy_o, 1'b1);
        step(1);
        check($sformatf("t2_gap%0d_ack", i), sleep_ack_o, 1'b0);
      end
    end
    check_all("t2_sleep", 1, 1, 1, 0, 0);

    // Incoming-request wake while the request is held, then lockout.
    incoming_req_i = 1'b1;
    step(1);
    incoming_req_i = 1'b0;
    check("t3_down", clock_down_o, 1'b0);
    check("t3_iso", isolate_o, 1'b1);
    check("t3_ack", sleep_ack_o, 1'b0);
    step(3);
    check("t3_iso_c4", isolate_o, 1'b1);
    step(1);
    check("t3_iso_c5", isolate_o, 1'b0);
    step(3);
    check("t3_lockout_iso", isolate_o, 1'b0);
    check("t3_lockout_ack", sleep_ack_o, 1'b0);
    sleep_req_i = 1'b0;
    step(1);
    sleep_req_i = 1'b1;
    step(1);
    check("t3_resleep_iso", isolate_o, 1'b1);
    step(1);
    check("t3_resleep_ack", sleep_ack_o, 1'b1);
    sleep_req_i = 1'b0;
    step(5);
    check("t3_exit_iso", isolate_o, 1'b0);

    // Read counter: simultaneous inc/dec holds at 2; non-last beats do not count.
    set_ar(1'b1);
    step(2);
    set_r(1'b1, 1'b1);
    step(1);
    set_ar(1'b0);
    set_r(1'b0, 1'b0);
    check("t4_same_busy", busy_o, 1'b1);
    check("t4_same_err", err_o, 1'b0);
    set_r(1'b1, 1'b0);
    step(2);
    set_r(1'b0, 1'b0);
    check("t4_nolast_busy", busy_o, 1'b1);
    set_r(1'b1, 1'b1);
    step(2);
    set_r(1'b0, 1'b0);
    check("t4_drained_busy", busy_o, 1'b0);
    check("t4_drained_err", err_o, 1'b0);
    set_b(1'b1);
    step(1);
    set_b(1'b0);
    check("t4_underflow_err", err_o, 1'b1);
    check("t4_underflow_busy", busy_o, 1'b0);

    // Only reset clears err; then abort a drain by dropping the request.
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    check("t5_err_cleared", err_o, 1'b0);
    set_aw(1'b1);
    step(1);
    set_aw(1'b0);
    sleep_req_i = 1'b1;
    step(1);
    check("t5_drain_iso", isolate_o, 1'b1);
    step(2);
    check("t5_hold_iso", isolate_o, 1'b1);
    check("t5_hold_ack", sleep_ack_o, 1'b0);
    sleep_req_i = 1'b0;
    step(1);
    check("t5_abort_iso", isolate_o, 1'b0);
    set_b(1'b1);
    step(1);
    set_b(1'b0);
    check("t5_final_busy", busy_o, 1'b0);
    check("t5_final_err", err_o, 1'b0);

    // Reset taken in SLEEP returns everything to idle on the next edge.
    sleep_req_i = 1'b1;
    step(2);
    check("t6_ack", sleep_ack_o, 1'b1);
    rst_i = 1'b1;
    sleep_req_i = 1'b0;
    step(1);
    check_all("t6_rst", 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    step(1);
    check_all("t6_after", 0, 0, 0, 0, 0);

    // Overflow boundary: 16 bursts fit, the 17th sets err.
    set_aw(1'b1);
    step(16);
    check("t7_at_max_err", err_o, 1'b0);
    step(1);
    set_aw(1'b0);
    check("t7_overflow_err", err_o, 1'b1);
    check("t7_overflow_busy", busy_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
